debug_mem_master: RTL and testbench

- Host-side initiator for the core's debug cache ports (InstCache and DataCache A2/WD2/WE2/RD2).
- Accepts single-word write commands and burst read commands over a valid/ready command channel.
- Drives the core's debug address, write-data and byte-write-enable ports, and returns read data over a valid/ready response channel.
- Used by the test host to load programs into InstCache and dump DataCache; keeps the core held in reset while any access is in flight.

---
 rtl/debug_mem_master.sv | 197 +++++++++++++++++++
 tb/tb_debug_mem_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_master.sv
// Debug initiator for the core's InstCache/DataCache second ports: single-word
// writes and burst reads, keeping the core in reset while any access runs.
module debug_mem_master #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_LEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_be,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_last,
  input  logic                 hold_req,
  output logic                 cpu_rst,
  output logic [31:0]          inst_a2,
  output logic [31:0]          inst_wd2,
  output logic [3:0]           inst_we2,
  input  logic [31:0]          inst_rd2,
  output logic [31:0]          data_a2,
  output logic [31:0]          data_wd2,
  output logic [3:0]           data_we2,
  input  logic [31:0]          data_rd2
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [31:0]          addr_cnt_reg;
  logic [MAX_LEN_W-1:0] beat_cnt_reg;
  logic [1:0]           wait_cnt_reg;
  logic                 sel_data_reg;
  logic                 rsp_valid_reg;
  logic                 rsp_last_reg;
  logic [31:0]          rsp_data_reg;

  logic [31:0] cmd_addr_aligned;
  logic [31:0] addr_inc;
  logic        cmd_fire;
  logic        accept_wr;
  logic        accept_rd;
  logic        write_done;
  logic        issue;
  logic        waiting;
  logic        wait_done;
  logic        capture;
  logic        rsp_fire;
  logic        advance;

  assign cmd_addr_aligned = cmd_addr & ~32'd3;
  assign addr_inc         = addr_cnt_reg + 32'd4;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next = cmd_op[1] ? RD_ISSUE : WRITE;
        end
      end
      WRITE:    state_next = IDLE;
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (wait_done) begin
          state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rsp_ready) begin
          state_next = rsp_last_reg ? IDLE : RD_ISSUE;
        end
      end
      default:  state_next = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    cmd_ready  = rst && (state_reg == IDLE);
    cpu_rst    = hold_req || (state_reg != IDLE);
    cmd_fire   = cmd_valid && cmd_ready;
    accept_wr  = cmd_fire && !cmd_op[1];
    accept_rd  = cmd_fire && cmd_op[1];
    write_done = (state_reg == WRITE);
    issue      = (state_reg == RD_ISSUE);
    waiting    = (state_reg == RD_WAIT);
    wait_done  = (wait_cnt_reg == 2'd0);
    capture    = waiting && wait_done;
    rsp_fire   = rsp_valid_reg && rsp_ready;
    advance    = (state_reg == RD_RESP) && rsp_ready && !rsp_last_reg;
  end

  // Burst sequencing and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_data_reg  <= 1'b0;
      addr_cnt_reg  <= 32'd0;
      beat_cnt_reg  <= '0;
      wait_cnt_reg  <= 2'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_last_reg  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        sel_data_reg <= cmd_op[0];
      end
      if (accept_rd) begin
        addr_cnt_reg <= cmd_addr_aligned;
        beat_cnt_reg <= cmd_len;
      end else if (advance) begin
        addr_cnt_reg <= addr_inc;
        beat_cnt_reg <= beat_cnt_reg - MAX_LEN_W'(1);
      end
      if (issue) begin
        wait_cnt_reg <= WAIT_INIT;
      end else if (waiting && !wait_done) begin
        wait_cnt_reg <= wait_cnt_reg - 2'd1;
      end
      if (capture) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= sel_data_reg ? data_rd2 : inst_rd2;
        rsp_last_reg  <= (beat_cnt_reg == '0);
      end else if (rsp_fire) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  // Per-port debug drivers; index 0 is InstCache, 1 is DataCache.
  // a2 is loaded as the state enters RD_ISSUE so the cache sees it a cycle early.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_ID = 1'(gi);
    logic        hit_cmd;
    logic [31:0] a2_reg;
    logic [31:0] wd2_reg;
    logic [3:0]  we2_reg;

    assign hit_cmd = (cmd_op[0] == PORT_ID);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a2_reg  <= 32'd0;
        wd2_reg <= 32'd0;
        we2_reg <= 4'd0;
      end else begin
        if (cmd_fire) begin
          a2_reg <= hit_cmd ? cmd_addr_aligned : 32'd0;
          if (accept_wr) begin
            wd2_reg <= hit_cmd ? cmd_wdata : 32'd0;
            we2_reg <= hit_cmd ? cmd_be : 4'd0;
          end
        end else if (advance && (sel_data_reg == PORT_ID)) begin
          a2_reg <= addr_inc;
        end
        if (write_done) begin
          we2_reg <= 4'd0;
        end
      end
    end
  end

  assign inst_a2   = g_port[0].a2_reg;
  assign inst_wd2  = g_port[0].wd2_reg;
  assign inst_we2  = g_port[0].we2_reg;
  assign data_a2   = g_port[1].a2_reg;
  assign data_wd2  = g_port[1].wd2_reg;
  assign data_we2  = g_port[1].we2_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_last  = rsp_last_reg;

endmodule

// File: tb/tb_debug_mem_master.sv
// Bench for debug_mem_master: transaction-level model plus directed vectors,
// with an RD_LATENCY=1 instance and a second RD_LATENCY=3 instance.
module tb_debug_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_last, hold_req, cpu_rst;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata, rsp_data;
  logic [3:0]  cmd_be;
  logic [7:0]  cmd_len;
  logic [31:0] inst_a2, inst_wd2, inst_rd2, data_a2, data_wd2, data_rd2;
  logic [3:0]  inst_we2, data_we2;

  logic        c3_cmd_valid, c3_cmd_ready, c3_rsp_valid, c3_rsp_ready, c3_rsp_last;
  logic        c3_hold_req, c3_cpu_rst;
  logic [1:0]  c3_cmd_op;
  logic [31:0] c3_cmd_addr, c3_cmd_wdata, c3_rsp_data;
  logic [3:0]  c3_cmd_be;
  logic [7:0]  c3_cmd_len;
  logic [31:0] c3_inst_a2, c3_inst_wd2, c3_inst_rd2, c3_data_a2, c3_data_wd2, c3_data_rd2;
  logic [3:0]  c3_inst_we2, c3_data_we2;

  debug_mem_master #(.RD_LATENCY(1), .MAX_LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .hold_req(hold_req), .cpu_rst(cpu_rst),
    .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2), .inst_rd2(inst_rd2),
    .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2)
  );

  debug_mem_master #(.RD_LATENCY(3), .MAX_LEN_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_op(c3_cmd_op),
    .cmd_addr(c3_cmd_addr), .cmd_wdata(c3_cmd_wdata), .cmd_be(c3_cmd_be), .cmd_len(c3_cmd_len),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
    .rsp_last(c3_rsp_last), .hold_req(c3_hold_req), .cpu_rst(c3_cpu_rst),
    .inst_a2(c3_inst_a2), .inst_wd2(c3_inst_wd2), .inst_we2(c3_inst_we2), .inst_rd2(c3_inst_rd2),
    .data_a2(c3_data_a2), .data_wd2(c3_data_wd2), .data_we2(c3_data_we2), .data_rd2(c3_data_rd2)
  );

  // Cache contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic is_data, input logic [31:0] a);
    return is_data ? (a ^ 32'h0000_1230) : (a ^ 32'hC0DE_0000);
  endfunction

  logic [31:0] c3_ipipe [3];
  logic [31:0] c3_dpipe [3];
  always @(posedge clk) begin
    inst_rd2    <= mem_word(1'b0, inst_a2);
    data_rd2    <= mem_word(1'b1, data_a2);
    c3_ipipe[0] <= mem_word(1'b0, c3_inst_a2);
    c3_ipipe[1] <= c3_ipipe[0];
    c3_ipipe[2] <= c3_ipipe[1];
    c3_dpipe[0] <= mem_word(1'b1, c3_data_a2);
    c3_dpipe[1] <= c3_dpipe[0];
    c3_dpipe[2] <= c3_dpipe[1];
  end
  assign c3_inst_rd2 = c3_ipipe[2];
  assign c3_data_rd2 = c3_dpipe[2];

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_rsp_t;

  int          tests = 0;
  int          fails = 0;
  exp_rsp_t    rdq [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  bit          rd_is_data, acc_flag, prev_stall, prev_last;
  logic [31:0] prev_data;
  bit          wr_pending, wr_is_data;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: one pending write slot and a queue of expected read beats.
  task automatic compare();
    bit busy;
    acc_flag = 1'b0;
    if (!rst) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_inst_we2", 32'(inst_we2), 32'd0);
      check("rst_data_we2", 32'(data_we2), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst), 32'(hold_req));
      rdq.delete();
      wr_pending = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    busy = (rdq.size() != 0) || wr_pending;
    check("cmd_ready", 32'(cmd_ready), 32'(!busy));
    check("cpu_rst", 32'(cpu_rst), 32'(hold_req || busy));
    if (wr_pending) begin
      check("wr_we2", 32'(wr_is_data ? data_we2 : inst_we2), 32'(wr_be));
      check("wr_a2", wr_is_data ? data_a2 : inst_a2, wr_addr);
      check("wr_wd2", wr_is_data ? data_wd2 : inst_wd2, wr_data);
      check("wr_other_we2", 32'(wr_is_data ? inst_we2 : data_we2), 32'd0);
      wr_pending = 1'b0;
    end else begin
      check("quiet_inst_we2", 32'(inst_we2), 32'd0);
      check("quiet_data_we2", 32'(data_we2), 32'd0);
    end
    if (prev_stall) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, prev_data);
      check("stall_last", 32'(rsp_last), 32'(prev_last));
    end
    if (rsp_valid) begin
      check("rsp_expected", 32'(rdq.size() != 0), 32'd1);
      if (rdq.size() != 0) begin
        check("rsp_data", rsp_data, rdq[0].data);
        check("rsp_last", 32'(rsp_last), 32'(rdq[0].last));
        check("idle_port_a2", rd_is_data ? inst_a2 : data_a2, 32'd0);
        if (rsp_ready) begin
          got_data.push_back(rsp_data);
          got_last.push_back(rsp_last);
          void'(rdq.pop_front());
        end
      end
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_data  = rsp_data;
    prev_last  = rsp_last;
    if (cmd_valid && cmd_ready) begin
      acc_flag = 1'b1;
      if (!cmd_op[1]) begin
        wr_pending = 1'b1;
        wr_is_data = cmd_op[0];
        wr_addr    = cmd_addr & ~32'd3;
        wr_data    = cmd_wdata;
        wr_be      = cmd_be;
      end else begin
        rd_is_data = cmd_op[0];
        for (int k = 0; k <= int'(cmd_len); k++) begin
          logic [31:0] a;
          a = (cmd_addr & ~32'd3) + 32'(4 * k);
          rdq.push_back('{data: mem_word(cmd_op[0], a), last: (k == int'(cmd_len))});
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [7:0] len);
    int n = 0;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be; cmd_len = len;
    cmd_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 50);
    check("cmd_accept", 32'(acc_flag), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rdq.size() != 0 || wr_pending) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 32'(rdq.size()), 32'd0);
  endtask

  initial begin
    int k, n, base;
    logic [31:0] exp_burst [4];
    logic [31:0] exp_wrap [3];
    exp_burst = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hC0DE_0108, 32'hC0DE_010C};
    exp_wrap  = '{32'hFFFF_EDC8, 32'hFFFF_EDCC, 32'h0000_1230};

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = '0; cmd_len = '0; rsp_ready = 1'b1; hold_req = 1'b0;
    c3_cmd_valid = 1'b0; c3_cmd_op = 2'b00; c3_cmd_addr = '0; c3_cmd_wdata = '0;
    c3_cmd_be = '0; c3_cmd_len = '0; c3_rsp_ready = 1'b1; c3_hold_req = 1'b0;
    @(posedge clk); #1;
    tick();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_inst_a2", inst_a2, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single write to InstCache
    send_cmd(2'b00, 32'h10, 32'hDEAD_BEEF, 4'hF, 8'd0);
    check("wr_inst_we2", 32'(inst_we2), 32'hF);
    check("wr_inst_a2", inst_a2, 32'h10);
    check("wr_inst_wd2", inst_wd2, 32'hDEAD_BEEF);
    check("wr_inst_data_we2", 32'(data_we2), 32'd0);
    check("wr_inst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("wr_inst_busy", 32'(cmd_ready), 32'd0);
    tick();
    check("wr_done_we2", 32'(inst_we2), 32'd0);
    check("wr_done_ready", 32'(cmd_ready), 32'd1);

    // be = 0 no-op, then a partial-byte DataCache write
    send_cmd(2'b01, 32'h23, 32'h5555_AAAA, 4'h0, 8'd0);
    tick();
    send_cmd(2'b01, 32'h20, 32'h0BAD_F00D, 4'h6, 8'd0);
    check("wr_data_a2", data_a2, 32'h20);
    check("wr_data_we2", 32'(data_we2), 32'h6);
    check("wr_data_inst_we2", 32'(inst_we2), 32'd0);
    tick();

    // Misaligned single read from DataCache
    send_cmd(2'b11, 32'h7, 32'd0, 4'd0, 8'd0);
    check("rd_a2_align", data_a2, 32'h4);
    wait_rsp(k);
    check("rd_latency", 32'(k), 32'd2);
    check("rd_data_lit", rsp_data, 32'h0000_1234);
    check("rd_last_lit", 32'(rsp_last), 32'd1);
    wait_idle();

    // Four-beat InstCache burst with rsp_ready toggling
    base = got_data.size();
    rsp_ready = 1'b0;
    send_cmd(2'b10, 32'h100, 32'd0, 4'd0, 8'd3);
    n = 0;
    while (got_data.size() < base + 4 && n < 100) begin
      rsp_ready = ~rsp_ready;
      tick();
      n++;
    end
    rsp_ready = 1'b1;
    check("burst_count", 32'(got_data.size() - base), 32'd4);
    if (got_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("burst_data", got_data[base+i], exp_burst[i]);
        check("burst_last", 32'(got_last[base+i]), 32'(i == 3));
      end
    end
    wait_idle();

    // Address wrap through the top of the 32-bit space
    base = got_data.size();
    send_cmd(2'b11, 32'hFFFF_FFF8, 32'd0, 4'd0, 8'd2);
    wait_idle();
    check("wrap_count", 32'(got_data.size() - base), 32'd3);
    if (got_data.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("wrap_data", got_data[base+i], exp_wrap[i]);
      end
    end

    // Asynchronous reset while beat 2 of a 5-beat burst is stalled
    base = got_data.size();
    send_cmd(2'b10, 32'h200, 32'd0, 4'd0, 8'd4);
    n = 0;
    while (got_data.size() < base + 1 && n < 50) begin
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    wait_rsp(k);
    check("beat2_valid", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_inst_we2", 32'(inst_we2), 32'd0);
    check("arst_data_we2", 32'(data_we2), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("arst_inst_a2", inst_a2, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    send_cmd(2'b01, 32'h40, 32'hCAFE_F00D, 4'h3, 8'd0);
    check("post_rst_we2", 32'(data_we2), 32'h3);
    check("post_rst_wd2", data_wd2, 32'hCAFE_F00D);
    tick();

    // hold_req alone keeps the core in reset
    hold_req = 1'b1;
    tick();
    check("hold_cpu_rst", 32'(cpu_rst), 32'd1);
    hold_req = 1'b0;
    tick();
    check("release_cpu_rst", 32'(cpu_rst), 32'd0);

    // RD_LATENCY = 3 instance: single DataCache read
    check("c3_ready", 32'(c3_cmd_ready), 32'd1);
    c3_cmd_op = 2'b11; c3_cmd_addr = 32'h30; c3_cmd_len = 8'd0; c3_cmd_valid = 1'b1;
    tick();
    c3_cmd_valid = 1'b0;
    k = 0;
    while (!c3_rsp_valid && k < 50) begin
      tick();
      k++;
    end
    check("c3_latency", 32'(k), 32'd4);
    check("c3_data", c3_rsp_data, 32'h0000_1200);
    check("c3_last", 32'(c3_rsp_last), 32'd1);
    check("c3_cpu_rst_busy", 32'(c3_cpu_rst), 32'd1);
    tick();
    c3_hold_req = 1'b1;
    tick();
    check("c3_hold_cpu_rst", 32'(c3_cpu_rst), 32'd1);
    check("c3_idle_ready", 32'(c3_cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
